// File: rtl/line_clear_anim_ctrl.sv
// line_clear_anim_ctrl
// Sequences the line-clear animation for the playfield. Full rows reported
// by game logic are latched on start_i, blinked in step with video frames
// through a row-override mask/colour, then handed back to game logic via a
// collapse request/acknowledge handshake, followed by a one-cycle done pulse.
//
// Ports:
//   clk_i            system/pixel clock
//   rst_i            synchronous active-high reset
//   frame_start_i    one-cycle pulse at start of vertical blank
//   start_i          one-cycle request to begin an animation
//   full_rows_i      rows to clear (sampled only with an accepted start_i)
//   busy_o           animation in progress (through the done_o cycle)
//   row_mask_o       rows the renderer overrides this frame
//   override_color_o palette index for overridden rows
//   collapse_req_o   request to game logic to remove collapse_rows_o
//   collapse_rows_o  latched rows, valid while collapse_req_o is high
//   collapse_ack_i   game logic finished collapsing
//   done_o           one-cycle completion pulse
//
// Handshake: collapse_req_o rises and stays high until collapse_ack_i is seen
// high on a clock edge while the request is up; the request then drops on the
// next cycle together with done_o rising. There is no timeout.
module line_clear_anim_ctrl #(
    parameter int ROW_CNT          = 20,
    parameter int COLOR_WIDTH      = 3,
    parameter int FLASH_COLOR      = 7,
    parameter int FRAMES_PER_PHASE = 15,
    parameter int BLINK_CNT        = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   frame_start_i,
    input  logic                   start_i,
    input  logic [ROW_CNT-1:0]     full_rows_i,
    output logic                   busy_o,
    output logic [ROW_CNT-1:0]     row_mask_o,
    output logic [COLOR_WIDTH-1:0] override_color_o,
    output logic                   collapse_req_o,
    output logic [ROW_CNT-1:0]     collapse_rows_o,
    input  logic                   collapse_ack_i,
    output logic                   done_o
);

    localparam int FCW = $clog2(FRAMES_PER_PHASE + 1);
    localparam int BCW = $clog2(BLINK_CNT + 1);

    localparam logic [FCW-1:0]         FRAME_LAST = FCW'(FRAMES_PER_PHASE - 1);
    localparam logic [BCW-1:0]         BLINK_LAST = BCW'(BLINK_CNT - 1);
    localparam logic [COLOR_WIDTH-1:0] FLASH      = COLOR_WIDTH'(FLASH_COLOR);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ON,
        ST_OFF,
        ST_COLLAPSE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_CNT-1:0] mask_q, mask_d;
    logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [BCW-1:0]     blink_cnt_q, blink_cnt_d;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;

        case (state_q)
            ST_IDLE: begin
                frame_cnt_d = '0;
                blink_cnt_d = '0;
                if (start_i) begin
                    if (full_rows_i != '0) begin
                        mask_d  = full_rows_i;
                        state_d = ST_SYNC;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            // Wait for a frame boundary so the mask never appears mid-frame.
            ST_SYNC: begin
                if (frame_start_i) begin
                    state_d = ST_ON;
                end
            end

            ST_ON: begin
                if (frame_start_i) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = ST_OFF;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end

            ST_OFF: begin
                if (frame_start_i) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        blink_cnt_d = blink_cnt_q + 1'b1;
                        state_d     = (blink_cnt_q == BLINK_LAST) ? ST_COLLAPSE : ST_ON;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end

            ST_COLLAPSE: begin
                if (collapse_ack_i) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // Outputs are registered from the next-state values so every output moves
    // exactly one clock after the input edge that caused it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o           <= 1'b0;
            row_mask_o       <= '0;
            override_color_o <= '0;
            collapse_req_o   <= 1'b0;
            collapse_rows_o  <= '0;
            done_o           <= 1'b0;
        end else begin
            busy_o           <= (state_d != ST_IDLE);
            row_mask_o       <= (state_d == ST_ON || state_d == ST_OFF ||
                                 state_d == ST_COLLAPSE) ? mask_d : '0;
            override_color_o <= (state_d == ST_ON) ? FLASH : '0;
            collapse_req_o   <= (state_d == ST_COLLAPSE);
            collapse_rows_o  <= (state_d == ST_COLLAPSE) ? mask_d : '0;
            done_o           <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_line_clear_anim_ctrl.sv
module tb_line_clear_anim_ctrl;

    localparam int ROWS  = 20;
    localparam int CW    = 3;
    localparam int FPP   = 2;
    localparam int BLINK = 2;
    localparam int FLASH = 7;
    localparam int FRAME_PERIOD = 10;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            frame_start_i = 1'b0;
    logic            start_i = 1'b0;
    logic [ROWS-1:0] full_rows_i = '0;
    logic            busy_o;
    logic [ROWS-1:0] row_mask_o;
    logic [CW-1:0]   override_color_o;
    logic            collapse_req_o;
    logic [ROWS-1:0] collapse_rows_o;
    logic            collapse_ack_i = 1'b0;
    logic            done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    line_clear_anim_ctrl #(
        .ROW_CNT(ROWS), .COLOR_WIDTH(CW), .FLASH_COLOR(FLASH),
        .FRAMES_PER_PHASE(FPP), .BLINK_CNT(BLINK)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start_i),
        .start_i(start_i), .full_rows_i(full_rows_i), .busy_o(busy_o),
        .row_mask_o(row_mask_o), .override_color_o(override_color_o),
        .collapse_req_o(collapse_req_o), .collapse_rows_o(collapse_rows_o),
        .collapse_ack_i(collapse_ack_i), .done_o(done_o)
    );

    // ---------------- reference model ----------------
    // An animation is described by the number of frame pulses seen since it
    // was accepted: pulse k>=1 belongs to blink phase (k-1)/FPP; even phases
    // are ON, odd are OFF; once all 2*BLINK phases are over the rows wait to
    // be collapsed.
    bit              m_active = 0;
    bit              m_done   = 0;
    int              m_frames = 0;
    logic [ROWS-1:0] m_mask   = '0;

    function automatic bit m_collapsing();
        return m_active && (m_frames >= 2 * BLINK * FPP + 1);
    endfunction

    task automatic model_step();
        if (rst_i) begin
            m_active = 0; m_done = 0; m_frames = 0; m_mask = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start_i) begin
                if (full_rows_i != '0) begin
                    m_active = 1; m_frames = 0; m_mask = full_rows_i;
                end else begin
                    m_done = 1;
                end
            end
        end else if (m_collapsing()) begin
            if (collapse_ack_i) begin
                m_active = 0; m_done = 1;
            end
        end else if (frame_start_i) begin
            m_frames++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [ROWS-1:0] e_mask;
        logic [CW-1:0]   e_col;
        bit              lit;
        lit    = m_active && m_frames >= 1;
        e_mask = lit ? m_mask : '0;
        e_col  = (lit && !m_collapsing() && (((m_frames - 1) / FPP) % 2 == 0)) ? CW'(FLASH) : '0;
        chk("busy",      32'(busy_o),           32'(m_active || m_done));
        chk("done",      32'(done_o),           32'(m_done));
        chk("row_mask",  32'(row_mask_o),       32'(e_mask));
        chk("color",     32'(override_color_o), 32'(e_col));
        chk("req",       32'(collapse_req_o),   32'(m_collapsing()));
        chk("rows",      32'(collapse_rows_o),  32'(m_collapsing() ? m_mask : '0));
    endtask

    // ---------------- driver ----------------
    // One clock: frame pulse on a fixed cadence, model and DUT see the same
    // sampled inputs, outputs compared 1 time unit after the edge.
    task automatic tick();
        frame_start_i = (cyc % FRAME_PERIOD == FRAME_PERIOD - 1);
        @(posedge clk_i);
        model_step();
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic pulse_start(input logic [ROWS-1:0] rows);
        start_i = 1'b1; full_rows_i = rows;
        tick();
        start_i = 1'b0; full_rows_i = '0;
    endtask

    task automatic wait_collapse(input int budget);
        int n = 0;
        while (!m_collapsing() && n < budget) begin
            tick();
            n++;
        end
        if (!m_collapsing()) chk("wait_req_timeout", 32'(collapse_req_o), 32'd1);
    endtask

    task automatic pulse_ack();
        collapse_ack_i = 1'b1;
        tick();
        collapse_ack_i = 1'b0;
    endtask

    initial begin
        logic [ROWS-1:0] r;
        // reset, then idle with frame pulses
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (50) tick();

        // full animation of rows 0/1, ignored restart during ON, ack after 5
        pulse_start(20'h00003);
        chk("busy_after_start", 32'(busy_o), 32'd1);
        while (!(m_active && m_frames >= 1) && cyc < 2000) tick();
        tick();
        pulse_start(20'h80000);
        wait_collapse(200);
        chk("rows_kept", 32'(collapse_rows_o), 32'h00003);
        repeat (4) tick();
        pulse_ack();
        chk("done_pulse", 32'(done_o), 32'd1);
        tick();
        chk("busy_drop", 32'(busy_o), 32'd0);
        repeat (5) tick();

        // empty start goes straight to done
        pulse_start('0);
        chk("empty_done", 32'(done_o), 32'd1);
        repeat (5) tick();

        // reset while collapse pending, late ack ignored, fresh run works
        pulse_start(20'h00410);
        wait_collapse(200);
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_req", 32'(collapse_req_o), 32'd0);
        pulse_ack();
        chk("late_ack", 32'(done_o), 32'd0);
        pulse_start(20'h0F000);
        wait_collapse(200);
        pulse_ack();
        chk("fresh_done", 32'(done_o), 32'd1);
        tick();

        // randomized traffic
        repeat (3000) begin
            r = ($urandom_range(0, 3) == 0) ? '0 : ROWS'($urandom);
            start_i        = ($urandom_range(0, 39) == 0);
            full_rows_i    = r;
            collapse_ack_i = m_collapsing() ? ($urandom_range(0, 5) == 0)
                                            : ($urandom_range(0, 30) == 0);
            rst_i          = ($urandom_range(0, 400) == 0);
            tick();
        end
        start_i = 0; collapse_ack_i = 0; rst_i = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
